alu_result_fifo: RTL and testbench
==================================

Name: alu_result_fifo

Overview:
- Downstream stage of the 8-bit ALU.
- Captures each 16-bit ALU result on the cycle the ALU asserts valid, and buffers it in a first-word-fall-through FIFO.
- Presents results to a consumer (scoreboard, bus bridge or display logic) over a ready/valid handshake.
- The ALU cannot be stalled, so overflow is detected, counted and flagged rather than back-pressured.

Parameters:
- DEPTH, 8: number of 16-bit entries; must be a power of 2, minimum 2.
- DW, 16: result width; matches the ALU output width.
- CW, 8: width of the dropped-result counter.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous reset, active-low; sampled on the rising edge of clk.
- in_result  input  DW  ALU result (the ALU out_put).
- in_valid  input  1  ALU result-valid strobe; one result per asserted cycle.
- out_data  output  DW  result at the FIFO head.
- out_valid  output  1  head entry valid.
- out_ready  input  1  consumer accepts the head this cycle.
- count  output  $clog2(DEPTH)+1  current occupancy.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- overflow  output  1  sticky: a result was dropped.
- drop_cnt  output  CW  number of dropped results; saturates at 2^CW-1.
- clr_ovf  input  1  clears overflow and drop_cnt.

Behaviour:
- Reset (rst low at a clock edge):
  - Pointers, count, overflow, drop_cnt and peak go to 0.
  - empty=1, full=0, out_valid=0, out_data=0.
  - Memory contents are don't-care.
  - A reset mid-operation discards all stored entries; no partial state survives.
- Pointers:
  - wr_ptr and rd_ptr are $clog2(DEPTH)+1 bits wide; the extra MSB disambiguates full from empty.
  - Both wrap naturally modulo 2*DEPTH.
- Push: in_valid=1 and not (full and no pop) → in_result written at wr_ptr, wr_ptr+1.
- Pop: out_valid && out_ready → rd_ptr+1.
- Output timing:
  - out_valid = !empty, driven combinationally from registered state.
  - out_data = mem[rd_ptr[addr]] when not empty, else 0.
  - First-word fall-through: a result pushed at edge N is visible on out_data after edge N (1-cycle latency).
- Simultaneous push and pop:
  - When full: both happen, count stays at DEPTH, nothing is dropped.
  - When empty: the pop is ignored (out_valid=0) and the push is accepted, giving count=1.
  - Otherwise: count is unchanged.
- Overflow:
  - Triggered by in_valid while full with no pop in the same cycle.
  - The result is discarded, overflow is set to 1, and drop_cnt increments, saturating at 2^CW-1.
- clr_ovf:
  - Clears overflow and drop_cnt at the next edge.
  - If a drop occurs in the same cycle, the drop wins: overflow=1, drop_cnt=1.
- out_ready while empty has no effect.
- count, full and empty are registered-derived and valid in the cycle after any push or pop.

Optional Feature:
- Macro: ALU_RESULT_PEAK_EN.
- Defined:
  - Adds output peak (DW bits), reset to 0, holding the maximum unsigned in_result ever accepted, dropped results excluded.
  - Update rule: peak <= max(peak, in_result) on each accepted push.
  - clr_ovf also clears peak.
- Undefined: the peak port and its logic are absent.

Decomposition:
- Package alu_pkg:
  - Holds ALU_DW=16 and ALU_OPW=8.
  - Holds the fn opcode enum, typedef alu_res_t = logic [15:0].
  - The FIFO uses alu_res_t for its data path.
- Sub-module fifo_ptr:
  - Parameterised pointer/flag logic: wr/rd pointer increment and wrap, full/empty compare, count.
  - Instantiated once.
  - Storage and overflow logic stay in the top module.

Test Plan:
- Reset, then 3 pushes of 0x0001, 0x00FF, 0xFE01 with out_ready=0 → count=3, out_data=0x0001, empty=0, full=0.
- Same FIFO, out_ready=1 for 3 cycles → out_data sequence 0x0001, 0x00FF, 0xFE01; then empty=1, out_valid=0, out_data=0.
- DEPTH=8: push 8 values, then push 0x1234 with out_ready=0 → full=1, overflow=1, drop_cnt=1, and the 0x1234 entry is never read back. Then pulse clr_ovf → overflow=0, drop_cnt=0.
- Fill to full, then apply in_valid=1 and out_ready=1 together for 4 cycles → count stays 8, no drop, FIFO order preserved across pointer wrap.
- Push 5 entries, drive rst=0 for one edge mid-stream → count=0, empty=1, overflow=0; the next push of 0x0042 appears at out_data after 1 cycle.
- With ALU_RESULT_PEAK_EN defined: push 0x0010, 0x8000, 0x0200 → peak=0x8000; a dropped 0xFFFF while full leaves peak unchanged.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the 8-bit ALU and its downstream stages.
//   ALU_DW    - ALU result width (16 bits: widest result is an 8x8 product)
//   ALU_OPW   - ALU operand width
//   alu_fn_e  - ALU function opcode
//   alu_res_t - ALU result word, used as the storage type of the result FIFO
package alu_pkg;

  localparam int ALU_DW  = 16;
  localparam int ALU_OPW = 8;

  typedef enum logic [3:0] {
    FN_ADD = 4'd0,
    FN_SUB = 4'd1,
    FN_MUL = 4'd2,
    FN_AND = 4'd3,
    FN_OR  = 4'd4,
    FN_XOR = 4'd5,
    FN_NOT = 4'd6,
    FN_SHL = 4'd7,
    FN_SHR = 4'd8
  } alu_fn_e;

  typedef logic [ALU_DW-1:0] alu_res_t;

endpackage

// File: rtl/fifo_ptr.sv
// fifo_ptr: read/write pointer and occupancy flags for a DEPTH-entry FIFO.
// Pointers carry one extra MSB so that full (equal address, differing MSB)
// and empty (identical pointers) are distinguishable; both wrap mod 2*DEPTH.
// Ports:
//   clk, rst (sync, active-low)
//   push, pop       - qualified push/pop strobes (caller guarantees legality)
//   wr_ptr, rd_ptr  - current pointers (PW bits)
//   count           - occupancy, wr_ptr - rd_ptr
//   full, empty     - count == DEPTH / count == 0
module fifo_ptr #(
  parameter int DEPTH = 8,
  parameter int PW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  output logic [PW-1:0] wr_ptr,
  output logic [PW-1:0] rd_ptr,
  output logic [PW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [PW-1:0] wr_ptr_d, wr_ptr_q;
  logic [PW-1:0] rd_ptr_d, rd_ptr_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Modular subtraction gives the occupancy directly, including across wrap.
  assign count  = wr_ptr_q - rd_ptr_q;
  assign full   = (count == PW'(DEPTH));
  assign empty  = (count == '0);
  assign wr_ptr = wr_ptr_q;
  assign rd_ptr = rd_ptr_q;

endmodule

// File: rtl/alu_result_fifo.sv
// alu_result_fifo: first-word-fall-through buffer for ALU results.
// The ALU cannot be stalled, so a result arriving while the FIFO is full
// (and nothing leaves that cycle) is dropped, flagged and counted.
// Ports:
//   clk, rst (sync, active-low)
//   in_result, in_valid        - ALU result and its strobe
//   out_data, out_valid,
//   out_ready                  - consumer ready/valid handshake on the head
//   count, full, empty         - occupancy status
//   overflow, drop_cnt, clr_ovf- sticky drop flag, saturating drop counter, clear
//   peak (ALU_RESULT_PEAK_EN)  - largest unsigned result ever accepted
// Optional feature macro: ALU_RESULT_PEAK_EN
module alu_result_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int DW    = ALU_DW,
  parameter int CW    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DW-1:0]            in_result,
  input  logic                     in_valid,
  output logic [DW-1:0]            out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow,
  output logic [CW-1:0]            drop_cnt,
`ifdef ALU_RESULT_PEAK_EN
  output logic [DW-1:0]            peak,
`endif
  input  logic                     clr_ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + CW'(1);
  endfunction

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          push, pop, drop;

  // A pop is only real when there is a head; a push into a full FIFO is
  // legal only when the head leaves in the same cycle.
  assign pop  = !empty && out_ready;
  assign push = in_valid && (!full || pop);
  assign drop = in_valid && full && !pop;

  fifo_ptr #(
    .DEPTH (DEPTH),
    .PW    (PW)
  ) u_ptr (
    .clk    (clk),
    .rst    (rst),
    .push   (push),
    .pop    (pop),
    .wr_ptr (wr_ptr),
    .rd_ptr (rd_ptr),
    .count  (count),
    .full   (full),
    .empty  (empty)
  );

  // Storage holds data only; contents after reset are don't-care.
  alu_res_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr[AW-1:0]] <= in_result;
  end

  assign out_valid = !empty;
  assign out_data  = empty ? '0 : mem_q[rd_ptr[AW-1:0]];

  logic          overflow_d, overflow_q;
  logic [CW-1:0] drop_cnt_d, drop_cnt_q;

  // A drop in the same cycle as clr_ovf wins: the clear happens first and
  // the new drop is recorded on top of it.
  always_comb begin
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (clr_ovf) begin
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end
    if (drop) begin
      overflow_d = 1'b1;
      drop_cnt_d = sat_inc(drop_cnt_d);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign overflow = overflow_q;
  assign drop_cnt = drop_cnt_q;

`ifdef ALU_RESULT_PEAK_EN
  function automatic logic [DW-1:0] max_u(input logic [DW-1:0] a, input logic [DW-1:0] b);
    return (a > b) ? a : b;
  endfunction

  logic [DW-1:0] peak_d, peak_q;

  // Only accepted results count; an accepted push in a clearing cycle
  // seeds the new peak.
  always_comb begin
    peak_d = clr_ovf ? '0 : peak_q;
    if (push) peak_d = max_u(peak_d, in_result);
  end

  always_ff @(posedge clk) begin
    if (!rst) peak_q <= '0;
    else      peak_q <= peak_d;
  end

  assign peak = peak_q;
`endif

endmodule

// File: tb/tb_alu_result_fifo.sv
module tb_alu_result_fifo;

  localparam int DEPTH = 8;
  localparam int DW    = 16;
  localparam int CW    = 8;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [DW-1:0]          in_result;
  logic                   in_valid;
  logic [DW-1:0]          out_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [$clog2(DEPTH):0] count;
  logic                   full;
  logic                   empty;
  logic                   overflow;
  logic [CW-1:0]          drop_cnt;
  logic                   clr_ovf;
`ifdef ALU_RESULT_PEAK_EN
  logic [DW-1:0]          peak;
`endif

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  alu_result_fifo #(.DEPTH(DEPTH), .DW(DW), .CW(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_result (in_result),
    .in_valid  (in_valid),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .overflow  (overflow),
    .drop_cnt  (drop_cnt),
`ifdef ALU_RESULT_PEAK_EN
    .peak      (peak),
`endif
    .clr_ovf   (clr_ovf)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit
  // after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    clr_ovf   = 1'b0;
    in_result = '0;
  endtask

  initial begin
    rst = 1'b0;
    idle();
    tick();
    tick();
    // Reset state
    check("rst_count", 32'(count), 0);
    check("rst_empty", 32'(empty), 1);
    check("rst_full", 32'(full), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_data", 32'(out_data), 0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_drop_cnt", 32'(drop_cnt), 0);
    rst = 1'b1;
    tick();

    // Three pushes with no consumer; first result visible one edge later
    in_valid = 1'b1; in_result = 16'h0001; tick();
    check("fwft_latency", 32'(out_data), 32'h0001);
    in_result = 16'h00FF; tick();
    in_result = 16'hFE01; tick();
    idle();
    check("p3_count", 32'(count), 3);
    check("p3_head", 32'(out_data), 32'h0001);
    check("p3_empty", 32'(empty), 0);
    check("p3_full", 32'(full), 0);

    // Drain in order
    out_ready = 1'b1;
    check("drain0", 32'(out_data), 32'h0001); tick();
    check("drain1", 32'(out_data), 32'h00FF); tick();
    check("drain2", 32'(out_data), 32'hFE01); tick();
    check("drain_empty", 32'(empty), 1);
    check("drain_out_valid", 32'(out_valid), 0);
    check("drain_out_data", 32'(out_data), 0);
    // out_ready while empty changes nothing
    tick();
    check("ready_on_empty_count", 32'(count), 0);
    idle();

    // Fill to DEPTH, then one more result is dropped
    in_valid = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      in_result = 16'h0100 + 16'(i);
      tick();
    end
    check("fill_full", 32'(full), 1);
    check("fill_count", 32'(count), DEPTH);
    in_result = 16'h1234; tick();
    idle();
    check("drop_full", 32'(full), 1);
    check("drop_overflow", 32'(overflow), 1);
    check("drop_cnt_1", 32'(drop_cnt), 1);
    check("drop_count", 32'(count), DEPTH);
    clr_ovf = 1'b1; tick(); idle();
    check("clr_overflow", 32'(overflow), 0);
    check("clr_drop_cnt", 32'(drop_cnt), 0);

    // Several drops, then a clear coinciding with a drop: the drop wins
    in_valid = 1'b1; in_result = 16'h1234;
    tick(); tick(); tick();
    check("drop_cnt_3", 32'(drop_cnt), 3);
    clr_ovf = 1'b1; tick(); idle();
    check("clr_drop_overflow", 32'(overflow), 1);
    check("clr_drop_cnt", 32'(drop_cnt), 1);

    // Saturation of the drop counter
    in_valid = 1'b1; in_result = 16'h1234;
    for (int i = 0; i < 300; i++) tick();
    idle();
    check("drop_cnt_sat", 32'(drop_cnt), 255);
    clr_ovf = 1'b1; tick(); idle();
    check("sat_clr_cnt", 32'(drop_cnt), 0);
    check("sat_clr_overflow", 32'(overflow), 0);

    // Full with simultaneous push and pop: no drop, order kept across wrap
    in_valid = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_result = 16'h0200 + 16'(k);
      check($sformatf("pp_head%0d", k), 32'(out_data), 32'h0100 + k);
      tick();
      check($sformatf("pp_count%0d", k), 32'(count), DEPTH);
    end
    in_valid = 1'b0;
    check("pp_no_drop", 32'(overflow), 0);
    check("pp_drop_cnt", 32'(drop_cnt), 0);
    for (int k = 0; k < DEPTH; k++) begin
      check($sformatf("wrap_rd%0d", k), 32'(out_data),
            (k < 4) ? (32'h0104 + k) : (32'h0200 + k - 4));
      tick();
    end
    check("wrap_empty", 32'(empty), 1);
    idle();

    // Build up state (including overflow), then reset mid-stream
    in_valid = 1'b1;
    for (int i = 0; i < DEPTH + 1; i++) begin
      in_result = 16'h0300 + 16'(i);
      tick();
    end
    idle();
    check("pre_rst_overflow", 32'(overflow), 1);
    out_ready = 1'b1; tick(); tick(); tick(); idle();
    check("pre_rst_count", 32'(count), 5);
    rst = 1'b0; tick(); rst = 1'b1;
    check("mid_rst_count", 32'(count), 0);
    check("mid_rst_empty", 32'(empty), 1);
    check("mid_rst_overflow", 32'(overflow), 0);
    check("mid_rst_drop_cnt", 32'(drop_cnt), 0);
    // Push and pop together while empty: pop ignored, push accepted
    in_valid = 1'b1; out_ready = 1'b1; in_result = 16'h0042; tick(); idle();
    check("post_rst_data", 32'(out_data), 32'h0042);
    check("post_rst_count", 32'(count), 1);
    check("post_rst_valid", 32'(out_valid), 1);
    out_ready = 1'b1; tick(); idle();
    check("post_rst_drained", 32'(empty), 1);

`ifdef ALU_RESULT_PEAK_EN
    rst = 1'b0; tick(); rst = 1'b1;
    check("peak_rst", 32'(peak), 0);
    in_valid = 1'b1;
    in_result = 16'h0010; tick();
    in_result = 16'h8000; tick();
    in_result = 16'h0200; tick();
    check("peak_max", 32'(peak), 32'h8000);
    in_result = 16'h0001;
    for (int i = 0; i < DEPTH - 3; i++) tick();
    check("peak_full", 32'(full), 1);
    in_result = 16'hFFFF; tick(); idle();
    check("peak_drop_ignored", 32'(peak), 32'h8000);
    check("peak_drop_cnt", 32'(drop_cnt), 1);
    clr_ovf = 1'b1; tick(); idle();
    check("peak_clr", 32'(peak), 0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
